// File: rtl/pal_ram_arbiter.sv
// Palette RAM port arbiter: renderer lookups have priority, CPU PPUDATA accesses
// are buffered and granted when the renderer is idle or after a bounded wait.
module pal_ram_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_en,
    input  logic       grayscale,
    input  logic       rnd_valid,
    input  logic [4:0] rnd_idx,
    output logic [5:0] rnd_color,
    output logic       rnd_cvalid,
    output logic       rnd_stall,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [4:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic       cpu_busy,
    output logic       cpu_ack,
    output logic [7:0] cpu_rdata,
    output logic [4:0] pal_addr,
    output logic       pal_we,
    output logic [7:0] pal_wdata,
    input  logic [7:0] pal_rdata
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_PEND  = 1'b1;
    localparam logic [7:0] LAST_CNT = 8'(STARVE_LIMIT - 1);

    logic [0:0] state_r;
    logic [7:0] cnt_r;
    logic       buf_we_r;
    logic [4:0] buf_addr_r;
    logic [5:0] buf_wdata_r;
    logic [5:0] rnd_color_r;
    logic       rnd_cvalid_r;
    logic       rnd_stall_r;
    logic       cpu_busy_r;
    logic       cpu_ack_r;
    logic [7:0] cpu_rdata_r;

    logic       steal_s;
    logic       cpu_own_s;
    logic       rnd_serve_s;
    logic [5:0] gray_mask_s;
    logic       unused_s;

    // Sprite backdrop entries $10/$14/$18/$1C alias the background backdrops.
    function automatic logic [4:0] mir(input logic [4:0] a);
        logic [4:0] m;
        if (a[4] && (a[1:0] == 2'b00)) begin
            m = {1'b0, a[3:0]};
        end else begin
            m = a;
        end
        return m;
    endfunction

    assign unused_s = ^{pal_rdata[7:6], cpu_wdata[7:6]};

    // Port ownership and palette RAM port mux for the current tick.
    always_comb begin
        steal_s     = 1'b0;
        cpu_own_s   = 1'b0;
        gray_mask_s = 6'h3F;
        if (state_r == ST_PEND) begin
            steal_s   = rnd_valid && (cnt_r == LAST_CNT);
            cpu_own_s = !rnd_valid || steal_s;
        end else begin
            steal_s   = 1'b0;
            cpu_own_s = 1'b0;
        end
        rnd_serve_s = rnd_valid && !cpu_own_s;
        if (grayscale) begin
            gray_mask_s = 6'h30;
        end else begin
            gray_mask_s = 6'h3F;
        end
        if (cpu_own_s) begin
            pal_addr  = mir(buf_addr_r);
            pal_wdata = {2'b00, buf_wdata_r};
            pal_we    = clk_en && buf_we_r;
        end else begin
            pal_addr  = mir(rnd_idx);
            pal_wdata = 8'h00;
            pal_we    = 1'b0;
        end
    end

    // CPU request buffer, starvation counter and completion handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 8'd0;
            buf_we_r    <= 1'b0;
            buf_addr_r  <= 5'd0;
            buf_wdata_r <= 6'd0;
            cpu_busy_r  <= 1'b0;
            cpu_ack_r   <= 1'b0;
            cpu_rdata_r <= 8'h00;
        end else begin
            cpu_ack_r <= 1'b0;
            if (clk_en) begin
                case (state_r)
                    ST_IDLE: begin
                        if (cpu_req) begin
                            buf_we_r    <= cpu_we;
                            buf_addr_r  <= cpu_addr;
                            buf_wdata_r <= cpu_wdata[5:0];
                            cpu_busy_r  <= 1'b1;
                            state_r     <= ST_PEND;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_PEND: begin
                        if (cpu_own_s) begin
                            if (!buf_we_r) begin
                                cpu_rdata_r <= {2'b00, pal_rdata[5:0]};
                            end else begin
                                cpu_rdata_r <= cpu_rdata_r;
                            end
                            cpu_ack_r  <= 1'b1;
                            cpu_busy_r <= 1'b0;
                            cnt_r      <= 8'd0;
                            state_r    <= ST_IDLE;
                        end else begin
                            cnt_r <= cnt_r + 8'd1;
                        end
                    end
                    default: begin
                        state_r    <= ST_IDLE;
                        cnt_r      <= 8'd0;
                        cpu_busy_r <= 1'b0;
                    end
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end

    // Renderer colour pipeline; a stolen slot reports stall and no new colour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rnd_color_r  <= 6'd0;
            rnd_cvalid_r <= 1'b0;
            rnd_stall_r  <= 1'b0;
        end else if (clk_en) begin
            if (rnd_serve_s) begin
                rnd_color_r  <= pal_rdata[5:0] & gray_mask_s;
                rnd_cvalid_r <= 1'b1;
            end else begin
                rnd_cvalid_r <= 1'b0;
            end
            rnd_stall_r <= steal_s;
        end else begin
            rnd_cvalid_r <= rnd_cvalid_r;
        end
    end

    assign rnd_color  = rnd_color_r;
    assign rnd_cvalid = rnd_cvalid_r;
    assign rnd_stall  = rnd_stall_r;
    assign cpu_busy   = cpu_busy_r;
    assign cpu_ack    = cpu_ack_r;
    assign cpu_rdata  = cpu_rdata_r;

endmodule

// File: tb/tb_pal_ram_arbiter.sv
// Directed bench for pal_ram_arbiter with a behavioural 32x8 palette RAM.
module tb_pal_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clk_en;
    logic       grayscale;
    logic       rnd_valid;
    logic [4:0] rnd_idx;
    logic [5:0] rnd_color;
    logic       rnd_cvalid;
    logic       rnd_stall;
    logic       cpu_req;
    logic       cpu_we;
    logic [4:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic       cpu_busy;
    logic       cpu_ack;
    logic [7:0] cpu_rdata;
    logic [4:0] pal_addr;
    logic       pal_we;
    logic [7:0] pal_wdata;
    logic [7:0] pal_rdata;

    logic [7:0] mem [32];
    int         checks = 0;
    int         errors = 0;
    int         we_count = 0;
    int         ack_count = 0;
    logic [4:0] last_we_addr = 5'd0;
    logic       ack_tick;
    logic       stall_tick;
    int         we_snap;
    int         ack_snap;

    always #5 clk = ~clk;

    pal_ram_arbiter #(.STARVE_LIMIT(8)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .grayscale(grayscale),
        .rnd_valid(rnd_valid), .rnd_idx(rnd_idx), .rnd_color(rnd_color),
        .rnd_cvalid(rnd_cvalid), .rnd_stall(rnd_stall), .cpu_req(cpu_req),
        .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_busy(cpu_busy), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .pal_addr(pal_addr), .pal_we(pal_we), .pal_wdata(pal_wdata),
        .pal_rdata(pal_rdata)
    );

    assign pal_rdata = mem[pal_addr];

    always @(posedge clk) begin
        if (pal_we) begin
            mem[pal_addr] <= pal_wdata;
            last_we_addr  <= pal_addr;
            we_count      <= we_count + 1;
        end
    end

    always @(negedge clk) begin
        if (cpu_ack) ack_count <= ack_count + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One PPU tick: one enabled clock followed by three disabled clocks.
    task automatic tick();
        clk_en = 1'b1;
        @(posedge clk);
        #1;
        ack_tick   = cpu_ack;
        stall_tick = rnd_stall;
        clk_en     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic cpu_access(input logic we, input logic [4:0] addr, input logic [7:0] data);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = data;
        tick();
        cpu_req = 1'b0;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; clk_en = 1'b0; grayscale = 1'b0; rnd_valid = 1'b0; rnd_idx = 5'd0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 5'd0; cpu_wdata = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_color",  32'(rnd_color),  32'h0);
        chk("rst_cvalid", 32'(rnd_cvalid), 32'h0);
        chk("rst_busy",   32'(cpu_busy),   32'h0);
        chk("rst_rdata",  32'(cpu_rdata),  32'h0);
        chk("rst_we",     32'(pal_we),     32'h0);
        rst_n = 1'b1;
        #1;

        // CPU write $11 to mirrored $10, renderer idle.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'h10; cpu_wdata = 8'h11;
        tick();
        chk("wr_busy",    32'(cpu_busy), 32'h1);
        chk("wr_noack",   32'(ack_tick), 32'h0);
        cpu_req = 1'b0;
        tick();
        chk("wr_ack",     32'(ack_tick), 32'h1);
        chk("wr_busy0",   32'(cpu_busy), 32'h0);
        chk("wr_ackdrop", 32'(cpu_ack),  32'h0);
        chk("wr_mirror",  32'(last_we_addr), 32'h00);
        chk("wr_mem0",    32'(mem[0]),   32'h11);
        cpu_access(1'b0, 5'h00, 8'h00);
        chk("rd_00",      32'(cpu_rdata), 32'h11);

        // Renderer lookups with grayscale masking.
        cpu_access(1'b1, 5'h03, 8'h2A);
        cpu_access(1'b1, 5'h05, 8'h07);
        cpu_access(1'b1, 5'h0D, 8'h15);
        rnd_valid = 1'b1; rnd_idx = 5'h03; grayscale = 1'b1;
        tick();
        chk("rnd_gray",   32'(rnd_color),  32'h20);
        chk("rnd_cvalid", 32'(rnd_cvalid), 32'h1);
        grayscale = 1'b0;
        tick();
        chk("rnd_color",  32'(rnd_color),  32'h2A);
        rnd_idx = 5'h10;
        tick();
        chk("rnd_mirror", 32'(rnd_color),  32'h11);
        rnd_valid = 1'b0;
        tick();
        chk("rnd_idle_cv",  32'(rnd_cvalid), 32'h0);
        chk("rnd_idle_col", 32'(rnd_color),  32'h11);

        // CPU read starved by a continuously valid renderer.
        rnd_valid = 1'b1; rnd_idx = 5'h03;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'h05;
        tick();
        cpu_req = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk("starve_noack",   32'(ack_tick),   32'h0);
            chk("starve_nostall", 32'(stall_tick), 32'h0);
        end
        tick();
        chk("starve_ack",    32'(ack_tick),   32'h1);
        chk("starve_stall",  32'(stall_tick), 32'h1);
        chk("starve_cvalid", 32'(rnd_cvalid), 32'h0);
        chk("starve_rdata",  32'(cpu_rdata),  32'h07);
        tick();
        chk("starve_stall0", 32'(stall_tick), 32'h0);
        chk("starve_cv1",    32'(rnd_cvalid), 32'h1);
        rnd_valid = 1'b0;

        // Non-mirrored $1D keeps only six bits and leaves $0D alone.
        cpu_access(1'b1, 5'h1D, 8'hFF);
        chk("wr1d_mem",  32'(mem[29]), 32'h3F);
        chk("wr0d_keep", 32'(mem[13]), 32'h15);
        cpu_access(1'b0, 5'h1D, 8'h00);
        chk("rd_1d",     32'(cpu_rdata), 32'h3F);

        // Request while busy is dropped; clk_en low freezes the wait count.
        ack_snap = ack_count;
        rnd_valid = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'h05;
        tick();
        cpu_addr = 5'h03;
        tick();
        cpu_req = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("freeze_busy", 32'(cpu_busy), 32'h1);
        chk("freeze_ack",  32'(ack_count - ack_snap), 32'h0);
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("frz_noack", 32'(ack_tick), 32'h0);
        end
        tick();
        chk("frz_ack",   32'(ack_tick),  32'h1);
        chk("frz_rdata", 32'(cpu_rdata), 32'h07);
        rnd_valid = 1'b0;
        tick();
        tick();
        chk("one_ack",   32'(ack_count - ack_snap), 32'h1);
        chk("busy_idle", 32'(cpu_busy), 32'h0);

        // Reset during PEND drops the buffered write.
        we_snap = we_count;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'h02; cpu_wdata = 8'h33;
        tick();
        cpu_req = 1'b0;
        chk("pre_rst_busy", 32'(cpu_busy), 32'h1);
        rst_n = 1'b0;
        #2;
        chk("mrst_busy",  32'(cpu_busy),   32'h0);
        chk("mrst_color", 32'(rnd_color),  32'h0);
        chk("mrst_rdata", 32'(cpu_rdata),  32'h0);
        chk("mrst_we",    32'(pal_we),     32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        tick();
        chk("mrst_nowe",   32'(we_count - we_snap), 32'h0);
        chk("mrst_noack",  32'(cpu_busy), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
